// File: rtl/iddr_gear_pkg.sv
// Shared constants and helpers for the DDR input gearbox.
// Phase selects which half-cycle pairing forms a 2-bit pair.
package iddr_gear_pkg;
   localparam int GEAR_MAX = 8;

   localparam logic PHASE_RF = 1'b0;
   localparam logic PHASE_FR = 1'b1;

   function automatic int cnt_width(input int gear);
      return (gear <= 1) ? 1 : $clog2(gear);
   endfunction
endpackage

// File: rtl/iddr_capture_x2.sv
// One DDR channel: rise/fall capture registers and the phase-selected pair mux.
// PHASE_RF pairs {rise_k, fall_k}; PHASE_FR pairs {fall_(k-1), rise_k}.
module iddr_capture_x2
   import iddr_gear_pkg::*;
(
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       d,
   input  logic       phase,
   output logic [1:0] pair
);
   logic p_q;
   logic fd_q;
   logic n0_q;
   logic n1_q;

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         p_q  <= 1'b0;
         fd_q <= 1'b0;
      end else begin
         p_q  <= d;
         fd_q <= n0_q;
      end
   end

   // Rise sample is retimed to the falling edge so both bits of a pair are stable at the next rise.
   always_ff @(negedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         n0_q <= 1'b0;
         n1_q <= 1'b0;
      end else begin
         n0_q <= d;
         n1_q <= p_q;
      end
   end

   always_comb begin
      pair = {n1_q, n0_q};
      if (phase == PHASE_FR) pair = {fd_q, n1_q};
   end
endmodule

// File: rtl/iddr_gearbox_xn.sv
// Multi-channel DDR deserialiser: packs GEAR pairs per channel into a word with a valid strobe.
// Shared pair counter, slip phase and priming flag drive all channels in lockstep.
//
//   phase    | meaning
//   PHASE_RF | pair = {rise_k, fall_k}
//   PHASE_FR | pair = {fall_(k-1), rise_k} (one-bit delayed alignment)
module iddr_gearbox_xn
   import iddr_gear_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int GEAR  = 2
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic [WIDTH-1:0]        D,
   input  logic                    CE,
   input  logic                    SLIP,
   output logic [WIDTH*2*GEAR-1:0] Q,
   output logic                    QVALID
);
   localparam int WW = 2 * GEAR;
   localparam int CW = cnt_width(GEAR);
   localparam logic [CW-1:0] CNT_LAST = CW'(GEAR - 1);

   if (GEAR < 1 || GEAR > GEAR_MAX) begin : g_gear_range
      $error("iddr_gearbox_xn: GEAR must be 1..%0d", GEAR_MAX);
   end

   logic [WIDTH*2-1:0]  pair;
   logic [WIDTH*WW-1:0] shifted;
   logic [WIDTH*WW-1:0] sr_q, sr_d;
   logic [WIDTH*WW-1:0] q_q, q_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                phase_q, phase_d;
   logic                prime_q, prime_d;
   logic                qvalid_q, qvalid_d;
   logic                slip_hold;

   for (genvar c = 0; c < WIDTH; c++) begin : g_ch
      iddr_capture_x2 u_cap (
         .clk_sys (CLK),
         .rst_n   (RSTN),
         .d       (D[c]),
         .phase   (phase_q),
         .pair    (pair[2*c +: 2])
      );
      assign shifted[c*WW +: WW] = (sr_q[c*WW +: WW] << 2) | WW'(pair[2*c +: 2]);
   end

   // Leaving PHASE_FR replays one pair without counting it, so the word boundary keeps moving later.
   assign slip_hold = SLIP && (phase_q == PHASE_FR);

   always_comb begin
      sr_d     = sr_q;
      q_d      = q_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      prime_d  = 1'b0;
      qvalid_d = 1'b0;
      if (!prime_q && CE) begin
         sr_d = shifted;
         if (SLIP) phase_d = ~phase_q;
         if (!slip_hold) begin
            if (cnt_q == CNT_LAST) begin
               q_d      = shifted;
               qvalid_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         sr_q     <= '0;
         q_q      <= '0;
         cnt_q    <= '0;
         phase_q  <= PHASE_RF;
         prime_q  <= 1'b1;
         qvalid_q <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         q_q      <= q_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         prime_q  <= prime_d;
         qvalid_q <= qvalid_d;
      end
   end

   assign Q      = q_q;
   assign QVALID = qvalid_q;
endmodule
